spi_master_dx: RTL
==================

SPI_MASTER_DX -- requirements
Module: spi_master_dx

Interface
REQ-001 Parameters SHALL be:
  - DATA_W, default 16: frame width in bits, legal 4..32.
  - CLK_DIV, default 1: s_clk half-period in clk cycles, legal 1..255.
  - CS_N_HOLD_COUNT, default 6'd3: extra clk cycles of cs_n-low setup and trail time.
REQ-002 Ports SHALL be:
  - clk  in  1  system clock; every register updates on its rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
  - spi_start  in  1  transfer request; sampled only in IDLE.
  - p_in  in  DATA_W  transmit word; captured on the accepted spi_start cycle.
  - cpol  in  1  s_clk idle level; captured with p_in.
  - cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; captured with p_in.
  - miso  in  1  serial receive data.
  - spi_ready  out  1  high only in IDLE.
  - p_out  out  DATA_W  last received word.
  - p_out_valid  out  1  one-cycle pulse when p_out updates.
  - s_clk  out  1  registered serial clock.
  - cs_n  out  1  active-low chip select.
  - mosi  out  1  serial transmit data, MSB first.

Function
REQ-003 FSM SHALL have four states, IDLE, SETUP, SHIFT and TRAIL, one-hot encoded; any illegal encoding SHALL go to IDLE.
REQ-004 In IDLE, spi_start=1 SHALL capture p_in, cpol and cpha and move to SETUP on the next edge; spi_start in any other state SHALL be ignored.
REQ-005 SETUP SHALL:
  - last CS_N_HOLD_COUNT+1 cycles;
  - hold cs_n=0 and s_clk=cpol;
  - present mosi=p_in[DATA_W-1] when cpha=0.
REQ-006 SHIFT SHALL produce exactly DATA_W s_clk periods, each 2*CLK_DIV clk cycles long.
REQ-007 In SHIFT, s_clk SHALL toggle every CLK_DIV cycles, starting at the idle level cpol; it SHALL be generated from a flop, with no gating logic.
REQ-008 With cpha=0, mosi SHALL change on trailing edges and miso SHALL be sampled on leading edges; with cpha=1, mosi SHALL change on leading edges and miso SHALL be sampled on trailing edges.
REQ-009 Received bits SHALL shift in MSB first; after DATA_W samples, p_out SHALL hold the full word.
REQ-010 TRAIL SHALL last CS_N_HOLD_COUNT+1 cycles with cs_n=0, s_clk=cpol and mosi=0, then go to IDLE.
REQ-011 On the TRAIL->IDLE edge, cs_n SHALL return to 1, spi_ready to 1, and p_out_valid SHALL pulse high for one cycle.
REQ-012 Transaction length, from the accepted start to spi_ready=1, SHALL be 2*(CS_N_HOLD_COUNT+1) + 2*DATA_W*CLK_DIV + 1 cycles.
REQ-013 spi_start held high through the cycle spi_ready rises SHALL start a new transfer back to back; cs_n SHALL stay high for at least one cycle between frames.
REQ-014 Bit and divider counters SHALL wrap to 0 when they reach their terminal counts; they SHALL NOT overflow into unused bits.
REQ-015 p_out SHALL keep its value until the next completed frame.

Reset
REQ-016 While rst_n=0, outputs SHALL be: state=IDLE, cs_n=1, s_clk=0, mosi=0, spi_ready=1, p_out=0, p_out_valid=0; all counters and shift registers SHALL be 0.
REQ-017 Reset asserted mid-transfer SHALL abort immediately: cs_n=1 asynchronously, no p_out_valid pulse, and p_out cleared.
REQ-018 After rst_n deasserts, the first spi_start SHALL be accepted on the first rising clk edge.

Configuration
REQ-019 Macro SPI_MASTER_DX_RX_EN defined: the receive shift register, p_out and p_out_valid SHALL function as specified.
REQ-020 Macro SPI_MASTER_DX_RX_EN undefined:
  - no receive logic is synthesised;
  - p_out SHALL be tied to 0 and p_out_valid to 0;
  - miso is unused;
  - all transmit timing SHALL be unchanged.

Verification
REQ-021 DATA_W=16, CLK_DIV=1, cpol=0, cpha=0, p_in=16'hA5C3, miso looped to mosi -> 16 rising s_clk edges, mosi stream A5C3 MSB first, p_out=16'hA5C3, p_out_valid one pulse, spi_ready high after 41 cycles.
REQ-022 Modes 1, 2 and 3 with CLK_DIV=3, p_in=16'h0001, miso driven 16'h8001 -> mosi changes on the edges given in REQ-008, p_out=16'h8001, each s_clk half-period 3 cycles.
REQ-023 rst_n pulsed low after the 5th bit of a transfer -> cs_n=1 within the reset window, no p_out_valid, p_out=0, next frame completes normally.
REQ-024 spi_start held high continuously -> back-to-back frames, cs_n high exactly 1 cycle between them, spi_start ignored during SETUP/SHIFT/TRAIL.
REQ-025 DATA_W=8, CS_N_HOLD_COUNT=0, CLK_DIV=2 -> SETUP 1 cycle, SHIFT 32 cycles, TRAIL 1 cycle; with SPI_MASTER_DX_RX_EN undefined, p_out_valid stays 0.

Source files
------------

// File: rtl/spi_master_dx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : spi_master_dx                                                    |
// | Function : SPI master, runtime cpol/cpha, cs_n setup/trail hold windows.    |
// |            Receive path present only when SPI_MASTER_DX_RX_EN is defined.   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module spi_master_dx #(
  parameter int         DATA_W          = 16,
  parameter int         CLK_DIV         = 1,
  parameter logic [5:0] CS_N_HOLD_COUNT = 6'd3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_start,
  input  logic [DATA_W-1:0] p_in,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              miso,
  output logic              spi_ready,
  output logic [DATA_W-1:0] p_out,
  output logic              p_out_valid,
  output logic              s_clk,
  output logic              cs_n,
  output logic              mosi
);

  localparam int                 c_BIT_W    = $clog2(DATA_W);
  localparam logic [7:0]         c_DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_W - 1);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SETUP = 4'b0010,
    ST_SHIFT = 4'b0100,
    ST_TRAIL = 4'b1000
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [5:0]           r_hold;
  logic [7:0]           r_div;
  logic [c_BIT_W-1:0]   r_bit;
  logic [DATA_W-1:0]    r_tx;
  logic                 r_cpol;
  logic                 r_cpha;
  logic                 r_sclk;
  logic                 r_mosi;
  logic                 w_hold_done;
  logic                 w_tick;
  logic                 w_lead;
  logic                 w_trail;
  logic                 w_last;

  assign w_hold_done = (r_hold == CS_N_HOLD_COUNT);
  assign w_tick      = (r_state == ST_SHIFT) && (r_div == c_DIV_LAST);
  // s_clk at its idle level means the coming toggle is a leading edge
  assign w_lead      = w_tick && (r_sclk == r_cpol);
  assign w_trail     = w_tick && (r_sclk != r_cpol);
  assign w_last      = w_trail && (r_bit == c_BIT_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (spi_start)   w_next = ST_SETUP;
      ST_SETUP: if (w_hold_done) w_next = ST_SHIFT;
      ST_SHIFT: if (w_last)      w_next = ST_TRAIL;
      ST_TRAIL: if (w_hold_done) w_next = ST_IDLE;
      default:                   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
      r_div  <= '0;
      r_bit  <= '0;
      r_tx   <= '0;
      r_cpol <= 1'b0;
      r_cpha <= 1'b0;
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (spi_start) begin
            r_cpol <= cpol;
            r_cpha <= cpha;
            r_sclk <= cpol;
            r_hold <= '0;
            r_div  <= '0;
            r_bit  <= '0;
            // cpha=0 must show the MSB before the first leading edge
            if (cpha) begin
              r_mosi <= 1'b0;
              r_tx   <= p_in;
            end else begin
              r_mosi <= p_in[DATA_W-1];
              r_tx   <= {p_in[DATA_W-2:0], 1'b0};
            end
          end
        end
        ST_SETUP, ST_TRAIL: begin
          r_hold <= w_hold_done ? '0 : r_hold + 6'd1;
        end
        ST_SHIFT: begin
          r_div <= w_tick ? '0 : r_div + 8'd1;
          if (w_tick) begin
            r_sclk <= ~r_sclk;
          end
          if (w_trail) begin
            r_bit <= w_last ? '0 : r_bit + c_BIT_W'(1);
          end
          if ((w_lead && r_cpha) || (w_trail && !r_cpha)) begin
            r_mosi <= r_tx[DATA_W-1];
            r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
          end
          if (w_last) begin
            r_mosi <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_clk     = r_sclk;
  assign mosi      = r_mosi;
  assign cs_n      = r_state[0];
  assign spi_ready = (r_state == ST_IDLE);

`ifdef SPI_MASTER_DX_RX_EN
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_p_out;
  logic              r_valid;
  logic              w_sample;
  logic              w_done;

  assign w_sample = (w_lead && !r_cpha) || (w_trail && r_cpha);
  assign w_done   = (r_state == ST_TRAIL) && w_hold_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx    <= '0;
      r_p_out <= '0;
      r_valid <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && spi_start) begin
        r_rx <= '0;
      end else if (w_sample) begin
        r_rx <= {r_rx[DATA_W-2:0], miso};
      end
      r_valid <= w_done;
      if (w_done) begin
        r_p_out <= r_rx;
      end
    end
  end

  assign p_out       = r_p_out;
  assign p_out_valid = r_valid;
`else
  logic w_unused_miso;
  assign w_unused_miso = miso;
  assign p_out         = '0;
  assign p_out_valid   = 1'b0;
`endif

endmodule
`default_nettype wire
